pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: INIT flush, load-use and redirect handling, memory wait.
// Optional saturating performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_miss;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_miss = mem_req && !mem_ack;

    // A count of 1 (or less, for degenerate FLUSH_CYCLES) means this is the last INIT cycle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            INIT: begin
                if (flush_cnt_q <= FC_W'(1)) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            RUN: begin
                if (mem_miss) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            flush_cnt_q <= FLUSH_INIT;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memory stall outranks redirect, which outranks the load-use bubble.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        busy         = 1'b0;
        case (state_q)
            INIT: begin
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_mem_wb = 1'b1;
                busy         = 1'b1;
            end
            RUN: begin
                if (mem_miss) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                    flush_mem_wb = 1'b1;
                end else if (ex_redirect) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                busy = 1'b1;
                if (!mem_ack) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                    flush_mem_wb = 1'b1;
                end
            end
            default: begin
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_mem_wb = 1'b1;
                busy         = 1'b1;
            end
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;
    logic             count_stall;
    logic             count_redirect;

    assign count_stall    = ((state_q == RUN) || (state_q == MEM_WAIT)) && stall_pc;
    assign count_redirect = (state_q == RUN) && ex_redirect && !mem_miss;

    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (count_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (count_redirect && (redirect_count_q != {CNT_W{1'b1}})) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
`else
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

endmodule
